// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit/receive pair: FSM encodings,
// bit-period arithmetic and the default frame sync byte.
package bpsk_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HUNT  = 3'd1,
        S_RECV  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int REF_CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUDRATE_DEFAULT     = 9600;

    function automatic int cycle_of(input int ref_hz, input int baud);
        return ref_hz / baud;
    endfunction

    localparam int CYCLE      = cycle_of(REF_CLK_FREQ_DEFAULT, BAUDRATE_DEFAULT);
    localparam int HALF_CYCLE = CYCLE / 2;

    localparam logic [7:0] SYNC_WORD = 8'hA5;

endpackage

// File: rtl/bpsk_bit_sampler.sv
// Bit-clock recovery: synchronises the demodulated phase bit, realigns the
// bit-period counter on every phase transition and strobes at mid-bit.
module bpsk_bit_sampler
    import bpsk_pkg::*;
#(
    parameter int CYCLE_LEN = CYCLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic phase_in,
    output logic strobe,
    output logic sample_bit
);

    localparam int SYNC_STAGES = 2;
    localparam logic [15:0] LAST_CNT = 16'(CYCLE_LEN - 1);
    localparam logic [15:0] HALF_CNT = 16'(CYCLE_LEN / 2);

    logic [SYNC_STAGES-1:0] phase_sync_reg;
    logic                   phase_dly_reg;
    logic                   phase_edge;
    logic [15:0]            cycle_cnt_reg;
    logic [15:0]            cycle_cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) phase_sync_reg[gi] <= 1'b0;
                    else        phase_sync_reg[gi] <= phase_in;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) phase_sync_reg[gi] <= 1'b0;
                    else        phase_sync_reg[gi] <= phase_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign phase_edge = phase_sync_reg[SYNC_STAGES-1] ^ phase_dly_reg;

    // A transition restarts the bit period so the strobe re-centres on the next bit.
    always_comb begin
        cycle_cnt_next = cycle_cnt_reg;
        if (!enable) begin
            cycle_cnt_next = '0;
        end else if (phase_edge || cycle_cnt_reg == LAST_CNT) begin
            cycle_cnt_next = '0;
        end else begin
            cycle_cnt_next = cycle_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_dly_reg <= 1'b0;
            cycle_cnt_reg <= '0;
        end else begin
            phase_dly_reg <= phase_sync_reg[SYNC_STAGES-1];
            cycle_cnt_reg <= cycle_cnt_next;
        end
    end

    assign strobe     = enable && (cycle_cnt_reg == HALF_CNT);
    assign sample_bit = phase_sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/bpsk_bit_receiver.sv
// BPSK receive framer: hunts for the sync byte, assembles MSB-first bytes and
// writes frame_length of them into the frame RAM from address 0.
module bpsk_bit_receiver
    import bpsk_pkg::*;
#(
    parameter int                    data_width   = 8,
    parameter int                    frame_length = 150,
    parameter int                    addr_width   = 8,
    parameter int                    ref_clk_freq = 100000000,
    parameter int                    baudrate     = 9600,
    parameter logic [data_width-1:0] sync_word    = data_width'(SYNC_WORD),
    parameter int                    hunt_timeout = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  recv_signal,
    input  logic                  phase_in,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_lost,
    output logic                  ram_clk,
    output logic                  ram_en,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    output logic [data_width-1:0] ram_wr_data,
    output logic                  ram_rst
);

    localparam int CYCLE_LEN = cycle_of(ref_clk_freq, baudrate);
    localparam int BIT_W     = $clog2(data_width);
    localparam int HUNT_W    = $clog2(hunt_timeout + 1);

    localparam logic [BIT_W-1:0]      BIT_TOP   = BIT_W'(data_width - 1);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(frame_length - 1);
    localparam logic [HUNT_W-1:0]     HUNT_MAX  = HUNT_W'(hunt_timeout);

    state_t                 state_reg, state_next;
    logic [2:0]             recv_sync_reg;
    logic                   start_event;
    logic                   strobe;
    logic                   sample_bit;
    logic [data_width-1:0]  shreg_reg, shreg_next, shreg_shifted;
    logic [data_width-1:0]  data_reg, data_next;
    logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [addr_width-1:0]  byte_cnt_reg, byte_cnt_next;
    logic [HUNT_W-1:0]      hunt_cnt_reg, hunt_cnt_next, hunt_inc;
    logic                   sync_lost_reg, sync_lost_next;

    // Two synchroniser flops plus a third for rising-edge detection of the arm request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) recv_sync_reg <= '0;
        else        recv_sync_reg <= {recv_sync_reg[1:0], recv_signal};
    end

    assign start_event = recv_sync_reg[1] & ~recv_sync_reg[2];

    bpsk_bit_sampler #(
        .CYCLE_LEN (CYCLE_LEN)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (state_reg != S_IDLE),
        .phase_in   (phase_in),
        .strobe     (strobe),
        .sample_bit (sample_bit)
    );

    assign shreg_shifted = {shreg_reg[data_width-2:0], sample_bit};
    assign hunt_inc      = hunt_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        data_next      = data_reg;
        bit_cnt_next   = bit_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        hunt_cnt_next  = hunt_cnt_reg;
        sync_lost_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_event) begin
                    state_next    = S_HUNT;
                    shreg_next    = '0;
                    byte_cnt_next = '0;
                    hunt_cnt_next = '0;
                end
            end
            S_HUNT: begin
                if (strobe) begin
                    shreg_next = shreg_shifted;
                    // A match on the timeout strobe still counts as sync.
                    if (shreg_shifted == sync_word) begin
                        state_next   = S_RECV;
                        bit_cnt_next = BIT_TOP;
                    end else if (hunt_inc == HUNT_MAX) begin
                        state_next     = S_IDLE;
                        sync_lost_next = 1'b1;
                    end else begin
                        hunt_cnt_next = hunt_inc;
                    end
                end
            end
            S_RECV: begin
                if (strobe) begin
                    data_next = {data_reg[data_width-2:0], sample_bit};
                    if (bit_cnt_reg == '0) state_next   = S_WRITE;
                    else                   bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
            S_WRITE: begin
                if (byte_cnt_reg == LAST_ADDR) begin
                    state_next = S_DONE;
                end else begin
                    state_next    = S_RECV;
                    byte_cnt_next = byte_cnt_reg + 1'b1;
                    bit_cnt_next  = BIT_TOP;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            data_reg      <= '0;
            bit_cnt_reg   <= BIT_TOP;
            byte_cnt_reg  <= '0;
            hunt_cnt_reg  <= '0;
            sync_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            data_reg      <= data_next;
            bit_cnt_reg   <= bit_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            hunt_cnt_reg  <= hunt_cnt_next;
            sync_lost_reg <= sync_lost_next;
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign frame_done  = (state_reg == S_DONE);
    assign sync_lost   = sync_lost_reg;
    assign ram_clk     = clk;
    assign ram_en      = 1'b1;
    assign ram_rst     = 1'b0;
    assign ram_we      = (state_reg == S_WRITE);
    assign ram_addr    = byte_cnt_reg;
    assign ram_wr_data = data_reg;

endmodule

// File: tb/tb_bpsk_bit_receiver.sv
// Randomised scoreboard bench for bpsk_bit_receiver with a bit-stream
// reference model (first sync-byte window, then frame_length bytes).
module tb_bpsk_bit_receiver;
    import bpsk_pkg::*;

    localparam int DW  = 8;
    localparam int FL  = 4;
    localparam int AW  = 8;
    localparam int REF = 1000;
    localparam int BAUD = 100;
    localparam int HT  = 16;
    localparam int PER = REF / BAUD;

    localparam int EV_WRITE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_LOST  = 2;

    typedef bit bitq_t[$];
    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          recv_signal = 1'b0;
    logic          phase_in = 1'b0;
    logic          busy, frame_done, sync_lost, ram_clk, ram_en, ram_we, ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    bpsk_bit_receiver #(
        .data_width   (DW),
        .frame_length (FL),
        .addr_width   (AW),
        .ref_clk_freq (REF),
        .baudrate     (BAUD),
        .sync_word    (8'hA5),
        .hunt_timeout (HT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .recv_signal (recv_signal),
        .phase_in    (phase_in),
        .busy        (busy),
        .frame_done  (frame_done),
        .sync_lost   (sync_lost),
        .ram_clk     (ram_clk),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wr_data (ram_wr_data),
        .ram_rst     (ram_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bitq_t byte_bits(input logic [7:0] b);
        bitq_t q;
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
        return q;
    endfunction

    // Reference: the line idles at 0, so the receiver's first 8-bit window
    // equal to the sync byte marks the frame; the next FL bytes get written.
    function automatic void model_frame(input bitq_t s);
        logic [7:0] win;
        int         idx;
        win = 8'h00;
        idx = -1;
        for (int i = 0; i < s.size(); i++) begin
            win = {win[6:0], s[i]};
            if (win == SYNC_WORD) begin
                idx = i;
                break;
            end
        end
        if (idx < 0 || s.size() < idx + 1 + 8 * FL) return;
        for (int b = 0; b < FL; b++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int k = 0; k < 8; k++) v = {v[6:0], s[idx + 1 + 8 * b + k]};
            exp_q.push_back('{EV_WRITE, b, int'(v)});
        end
        exp_q.push_back('{EV_DONE, 0, 0});
    endfunction

    task automatic send_bits(input bitq_t s, input int per);
        for (int i = 0; i < s.size(); i++) begin
            phase_in = s[i];
            repeat (per) @(negedge clk);
        end
    endtask

    task automatic arm();
        @(negedge clk);
        recv_signal = 1'b1;
        repeat (2) @(negedge clk);
        recv_signal = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles, output int waited);
        waited = 0;
        while (exp_q.size() != 0 && waited < max_cycles) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input string name, input bitq_t garbage,
                             input logic [7:0] pay [FL], input int per);
        bitq_t s;
        int    w;
        s = garbage;
        s = {s, byte_bits(SYNC_WORD)};
        for (int i = 0; i < FL; i++) s = {s, byte_bits(pay[i])};
        model_frame(s);
        $display("frame %s per=%0d garbage=%0d bytes=%h %h %h %h", name, per,
                 garbage.size(), pay[0], pay[1], pay[2], pay[3]);
        arm();
        repeat (4) @(negedge clk);
        send_bits(s, per);
        drain(name, 200, w);
        repeat (2) @(negedge clk);
        chk({name, "_busy_idle"}, busy, 0);
        phase_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Monitor: every output event pops and checks the scoreboard.
    initial begin
        ev_t e;
        bit  prev_last_write;
        bit  prev_done;
        prev_last_write = 0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_last_write = 0;
                prev_done = 0;
                continue;
            end
            if (prev_done) chk("busy_after_done", busy, 0);
            if (ram_we) begin
                $display("write addr=%0d data=%h", ram_addr, ram_wr_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=none", ram_addr, ram_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_kind", EV_WRITE, e.kind);
                    chk("write_addr", int'(ram_addr), e.addr);
                    chk("write_data", int'(ram_wr_data), e.data);
                end
            end
            if (frame_done) begin
                $display("frame_done");
                chk("done_after_last_write", int'(prev_last_write), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", EV_DONE, e.kind);
                end
            end
            if (sync_lost) begin
                $display("sync_lost");
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sync_lost actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("lost_kind", EV_LOST, e.kind);
                    chk("lost_not_busy", busy, 0);
                end
            end
            prev_last_write = ram_we && (ram_addr == AW'(FL - 1));
            prev_done = frame_done;
        end
    end

    initial begin
        bitq_t      g;
        bitq_t      s;
        logic [7:0] pay [FL];
        logic [7:0] fixed [FL];
        int         w;

        fixed[0] = 8'h11; fixed[1] = 8'h22; fixed[2] = 8'h33; fixed[3] = 8'h44;

        // Reset with a toggling line, then idle.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            phase_in = ~phase_in;
        end
        chk("rst_busy", busy, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_en", ram_en, 1);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_wr_data", int'(ram_wr_data), 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sync_lost", sync_lost, 0);
        chk("rst_ram_rst", ram_rst, 0);
        chk("ram_clk_follows_clk", ram_clk, clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i % 4 == 0) phase_in = ~phase_in;
        end
        chk("idle_busy", busy, 0);
        chk("idle_ram_addr", int'(ram_addr), 0);
        phase_in = 1'b0;
        repeat (10) @(negedge clk);

        g.delete();
        run_frame("nominal", g, fixed, PER);
        run_frame("skew11", g, fixed, PER + 1);
        run_frame("skew9", g, fixed, PER - 1);
        g.delete();
        g.push_back(1'b0); g.push_back(1'b1); g.push_back(1'b1);
        run_frame("garbage011", g, fixed, PER);

        // Random payloads with short random leading garbage.
        for (int f = 0; f < 6; f++) begin
            g.delete();
            for (int i = 0; i < $urandom_range(0, 4); i++) g.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < FL; i++) pay[i] = 8'($urandom_range(0, 255));
            run_frame("random", g, pay, PER);
        end

        // Line stuck at 1: the hunt gives up after HT strobes.
        phase_in = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back('{EV_LOST, 0, 0});
        $display("sync timeout run");
        arm();
        drain("sync_timeout", HT * PER + 100, w);
        chk("timeout_latency_window", int'(w >= HT * PER - 10 && w <= HT * PER + 15), 1);
        repeat (3) @(negedge clk);
        chk("timeout_busy", busy, 0);
        phase_in = 1'b0;
        repeat (10) @(negedge clk);

        // Mid-frame: re-arm during RECV is ignored, then reset aborts byte 2.
        for (int i = 0; i < FL; i++) pay[i] = 8'($urandom_range(0, 255));
        exp_q.push_back('{EV_WRITE, 0, int'(pay[0])});
        exp_q.push_back('{EV_WRITE, 1, int'(pay[1])});
        $display("midframe bytes=%h %h %h", pay[0], pay[1], pay[2]);
        arm();
        repeat (4) @(negedge clk);
        s = byte_bits(SYNC_WORD);
        s = {s, byte_bits(pay[0])};
        send_bits(s, PER);
        recv_signal = 1'b1;
        send_bits(byte_bits(pay[1]), PER);
        recv_signal = 1'b0;
        s = byte_bits(pay[2]);
        s = s[0:3];
        send_bits(s, PER);
        drain("midframe", 30, w);
        chk("midframe_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", int'(ram_addr), 0);
        chk("midrst_ram_wr_data", int'(ram_wr_data), 0);
        chk("midrst_ram_en", ram_en, 1);
        phase_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        g.delete();
        for (int i = 0; i < FL; i++) pay[i] = 8'($urandom_range(0, 255));
        run_frame("after_reset", g, pay, PER);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/bpsk_bit_receiver.md
Name: bpsk_bit_receiver

Overview:
Receive-side counterpart of the BPSK phase-control transmitter. The block takes the demodulator's hard-decision phase bit and recovers the bit clock at the configured baud rate. It hunts for a sync byte, assembles the following bytes MSB-first, and writes `frame_length` bytes into a BRAM port starting at address 0. It sits between the BPSK demodulator output and the frame RAM read by the PS.

Parameters:
- data_width, 8, byte width; also the width of the sync shift register.
- frame_length, 150, number of payload bytes written per frame after sync.
- addr_width, 8, RAM address width; must satisfy frame_length ≤ 2^addr_width.
- ref_clk_freq, 100000000, clk frequency in Hz.
- baudrate, 9600, bit rate in bit/s. CYCLE = ref_clk_freq/baudrate must be ≤ 65535 and ≥ 4.
- sync_word, 8'hA5, byte that marks the start of a frame.
- hunt_timeout, 1024, bit periods allowed in HUNT before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- recv_signal  in  1  arm request; a rising edge starts a reception
- phase_in  in  1  demodulated phase bit (asynchronous to clk)
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last byte is written
- sync_lost  out  1  one-cycle pulse on HUNT timeout
- ram_clk  out  1  tied to clk
- ram_en  out  1  RAM enable
- ram_addr  out  addr_width  RAM write address
- ram_we  out  1  write strobe
- ram_wr_data  out  data_width  byte to write
- ram_rst  out  1  tied to 0

Behaviour:
- Reset values: busy=0, frame_done=0, sync_lost=0, ram_en=1, ram_we=0, ram_addr=0, ram_wr_data=0. Internal: cycle_cnt=0, bit_cnt=data_width-1, byte_cnt=0, shreg=0, state=IDLE.
- Input conditioning:
  - recv_signal and phase_in each pass through a 2-flop synchronizer.
  - The start event is a rising edge on the synchronized recv_signal (3rd flop compare).
  - A phase edge is any change between synchronized phase_in and its 1-cycle delayed copy.
- Bit timing (active in HUNT and RECV/WRITE):
  - cycle_cnt counts 0..CYCLE-1 and wraps.
  - A detected phase edge forces cycle_cnt to 0 on the next clock; this is the realignment.
  - Sample strobe fires when cycle_cnt == CYCLE/2 (integer division), latching the synchronized phase_in.
  - In IDLE, cycle_cnt is held at 0.
- State machine:
  - IDLE:
    - On the start event, go to HUNT. shreg=0, byte_cnt=0, hunt bit counter=0.
    - Start events are ignored in every other state; there is no re-arm mid-frame.
  - HUNT:
    - On each strobe, shreg <= {shreg[data_width-2:0], bit}.
    - If the new shreg equals sync_word, go to RECV with bit_cnt=data_width-1.
    - Else increment the hunt counter. When it reaches hunt_timeout, pulse sync_lost and go to IDLE.
    - A sync match on the same strobe as the timeout wins.
  - RECV:
    - On each strobe, shift the bit into the data register (MSB-first) and decrement bit_cnt.
    - On the strobe where bit_cnt==0, go to WRITE.
  - WRITE (exactly 1 cycle):
    - ram_we=1, ram_addr=byte_cnt, ram_wr_data=assembled byte.
    - If byte_cnt == frame_length-1, go to DONE. Else byte_cnt+1, bit_cnt=data_width-1, back to RECV.
    - cycle_cnt keeps running; a strobe cannot fall in WRITE because CYCLE ≥ 4.
  - DONE (1 cycle): frame_done=1, then IDLE. ram_addr holds its last value.
- ram_we is high only in the WRITE cycle. Write latency is 1 clk after the strobe of the 8th bit.
- Total writes per frame equal frame_length exactly. The address never wraps.
- Asserting rst_n low mid-frame aborts immediately; no partial-byte write occurs.

Decomposition:
- Shared package (bpsk_pkg):
  - state encodings S_IDLE/S_HUNT/S_RECV/S_WRITE/S_DONE, 3 bits
  - CYCLE and HALF_CYCLE localparams derived from ref_clk_freq/baudrate
  - default SYNC_WORD, shared with the transmitter
- One sub-module, bpsk_bit_sampler: synchronizer, edge detect, cycle_cnt with realignment, sample strobe, and sampled-bit outputs. Enabled by the FSM.

Test Plan (sim params: ref_clk_freq=1000, baudrate=100 so CYCLE=10; frame_length=4):
- Reset then idle: rst_n low for 3 clk, phase_in toggling -> busy=0, ram_we=0, ram_en=1, ram_addr=0, no pulses.
- Nominal frame: pulse recv_signal, then drive bits A5,11,22,33,44 MSB-first at 10 clk/bit -> 4 writes at addrs 0..3 with data 11,22,33,44, each ram_we 1 clk wide. frame_done pulses once, 1 clk after the write to addr 3; busy then drops.
- Timing skew: same frame with the phase_in bit period 11 clk for one frame, 9 clk for another -> edge realignment still yields identical RAM contents.
- Sync timeout: arm with phase_in held at 1, hunt_timeout=16 -> sync_lost pulses after 16 strobes (~16*10 clk), no writes, state returns to IDLE.
- Leading garbage before sync: bits 0,1,1 then A5 then payload -> sync found on the correct boundary (shreg==A5); payload is written unchanged.
- Mid-frame reset and re-arm: rst_n low after byte 2 is written -> outputs return to reset values. A re-arm during RECV (before reset) is ignored. A new frame after reset writes from addr 0.
